// File: rtl/mips_pkg.sv
// Shared MIPS core constants: mult/div unit latencies and the MD op encodings
// used by the decoder, the MDU and the stall controller.
package mips_pkg;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   // Bit 1 of the op encoding separates the divide family from the multiply family.
   function automatic logic md_op_is_div(input md_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy-window counter for the multi-cycle mult/div unit: loads the op latency on
// start, counts down to zero, and reports busy while non-zero.
module md_busy_counter
   import mips_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int MULT_LAT_P = MULT_LAT,
   parameter int DIV_LAT_P  = DIV_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic load_div,
   output logic busy
);

   localparam logic [CNT_W-1:0] MULT_VAL = CNT_W'(MULT_LAT_P);
   localparam logic [CNT_W-1:0] DIV_VAL  = CNT_W'(DIV_LAT_P);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // A start while already busy simply reloads, so the newest op sets the window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_div ? DIV_VAL : MULT_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/md_stall_ctrl.sv
// Pipeline stall/flush scheduler: merges MDU busy stalls with the decoder's data
// hazard and fans out enables/flushes so D/E takes a bubble while E/M keeps flowing.
module md_stall_ctrl
   import mips_pkg::*;
#(
   parameter int MULT_LAT_P = MULT_LAT,
   parameter int DIV_LAT_P  = DIV_LAT,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              E_md_start,
   input  logic              E_md_is_div,
   input  logic              D_md_use,
   input  logic              D_data_hazard,
   output logic              md_start,
   output logic              md_busy,
   output logic              stall,
   output logic              fd_enable,
   output logic              de_enable,
   output logic              de_flush,
   output logic              em_enable,
   output logic              em_flush,
   output logic              mw_enable,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

   // Start is gated by reset so nothing reaches the MDU while the core is held.
   assign md_start = E_md_start & reset;

   md_busy_counter #(
      .CNT_W      (CNT_W),
      .MULT_LAT_P (MULT_LAT_P),
      .DIV_LAT_P  (DIV_LAT_P)
   ) u_busy (
      .clk      (clk),
      .reset    (reset),
      .load     (md_start),
      .load_div (E_md_is_div),
      .busy     (md_busy)
   );

   // A D-stage MDU user must also wait on an op starting in E this very cycle.
   assign stall = D_data_hazard | (D_md_use & (md_busy | md_start));

   assign fd_enable = ~stall;
   assign de_enable = 1'b1;
   assign de_flush  = stall;
   assign em_enable = 1'b1;
   assign em_flush  = 1'b0;
   assign mw_enable = 1'b1;

   // Saturating stall-cycle counter for performance monitoring.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + PERF_ONE;
      end
   end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-index model.
module tb_md_stall_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic E_md_start, E_md_is_div, D_md_use, D_data_hazard;

   logic        md_start, md_busy, stall;
   logic        fd_enable, de_enable, de_flush, em_enable, em_flush, mw_enable;
   logic [15:0] stall_cycles;

   logic        md_start4, md_busy4, stall4;
   logic        fd_enable4, de_enable4, de_flush4, em_enable4, em_flush4, mw_enable4;
   logic [3:0]  stall_cycles4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   md_stall_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .E_md_start    (E_md_start),
      .E_md_is_div   (E_md_is_div),
      .D_md_use      (D_md_use),
      .D_data_hazard (D_data_hazard),
      .md_start      (md_start),
      .md_busy       (md_busy),
      .stall         (stall),
      .fd_enable     (fd_enable),
      .de_enable     (de_enable),
      .de_flush      (de_flush),
      .em_enable     (em_enable),
      .em_flush      (em_flush),
      .mw_enable     (mw_enable),
      .stall_cycles  (stall_cycles)
   );

   md_stall_ctrl #(.PERF_W(4)) dut4 (
      .clk           (clk),
      .reset         (reset),
      .E_md_start    (E_md_start),
      .E_md_is_div   (E_md_is_div),
      .D_md_use      (D_md_use),
      .D_data_hazard (D_data_hazard),
      .md_start      (md_start4),
      .md_busy       (md_busy4),
      .stall         (stall4),
      .fd_enable     (fd_enable4),
      .de_enable     (de_enable4),
      .de_flush      (de_flush4),
      .em_enable     (em_enable4),
      .em_flush      (em_flush4),
      .mw_enable     (mw_enable4),
      .stall_cycles  (stall_cycles4)
   );

   // Model: busy in cycle c iff the latest start was in cycle s with s < c <= s+lat.
   int  cyc      = 0;
   int  ls_cyc   = 0;
   int  ls_lat   = 0;
   bit  ls_valid = 0;
   int  cnt16    = 0;
   int  cnt4     = 0;

   function automatic bit m_busy();
      return reset && ls_valid && (cyc > ls_cyc) && (cyc <= ls_cyc + ls_lat);
   endfunction

   function automatic bit m_start();
      return reset && E_md_start;
   endfunction

   function automatic bit m_stall();
      return D_data_hazard || (D_md_use && (m_busy() || m_start()));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ls_valid = 0;
         cnt16    = 0;
         cnt4     = 0;
      end else if (clk) begin
         if (m_stall()) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (E_md_start) begin
            ls_cyc   = cyc;
            ls_lat   = E_md_is_div ? 10 : 5;
            ls_valid = 1;
         end
         cyc++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("md_start",      32'(md_start),      32'(m_start()));
      checkOutput("md_busy",       32'(md_busy),       32'(m_busy()));
      checkOutput("stall",         32'(stall),         32'(m_stall()));
      checkOutput("fd_enable",     32'(fd_enable),     32'(!m_stall()));
      checkOutput("de_flush",      32'(de_flush),      32'(m_stall()));
      checkOutput("de_enable",     32'(de_enable),     32'd1);
      checkOutput("em_enable",     32'(em_enable),     32'd1);
      checkOutput("em_flush",      32'(em_flush),      32'd0);
      checkOutput("mw_enable",     32'(mw_enable),     32'd1);
      checkOutput("stall_cycles",  32'(stall_cycles),  32'(cnt16));
      checkOutput("stall_cycles4", 32'(stall_cycles4), 32'(cnt4));
      checkOutput("md_busy4",      32'(md_busy4),      32'(m_busy()));
   end

   task automatic applyStimulus(input bit st, input bit dv, input bit use_md, input bit haz);
      @(posedge clk);
      #1;
      E_md_start    = st;
      E_md_is_div   = dv;
      D_md_use      = use_md;
      D_data_hazard = haz;
   endtask

   task automatic do_reset();
      applyStimulus(0, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      E_md_start = 0; E_md_is_div = 0; D_md_use = 0; D_data_hazard = 0;
      #2;
      checkOutput("rst_busy", 32'(md_busy), 32'd0);
      checkOutput("rst_start", 32'(md_start), 32'd0);
      checkOutput("rst_perf", 32'(stall_cycles), 32'd0);
      do_reset();

      // Scenario 1: mult with mfhi waiting in D.
      applyStimulus(1, 0, 1, 0);
      @(negedge clk);
      checkOutput("t1_start", 32'(md_start), 32'd1);
      checkOutput("t1_stall_t", 32'(stall), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(0, 0, 1, 0);
         @(negedge clk);
         checkOutput("t1_busy", 32'(md_busy), 32'(i <= 5));
         checkOutput("t1_stall", 32'(stall), 32'(i <= 5));
      end
      checkOutput("t1_fd_en", 32'(fd_enable), 32'd1);

      // Scenario 2: div with no MDU user in D never stalls.
      do_reset();
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t2_stall_t", 32'(stall), 32'd0);
      for (int i = 1; i <= 11; i++) begin
         applyStimulus(0, 0, 0, 0);
         @(negedge clk);
         checkOutput("t2_busy", 32'(md_busy), 32'(i <= 10));
         checkOutput("t2_stall", 32'(stall), 32'd0);
         checkOutput("t2_flush", 32'(de_flush), 32'd0);
      end

      // Scenario 3: three-cycle data hazard.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1);
         @(negedge clk);
         checkOutput("t3_stall", 32'(stall), 32'd1);
         checkOutput("t3_fd_en", 32'(fd_enable), 32'd0);
      end
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t3_stall_end", 32'(stall), 32'd0);
      checkOutput("t3_perf", 32'(stall_cycles), 32'd3);

      // Scenario 4: div restarted by a mult two cycles later.
      do_reset();
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_restart", 32'(md_start), 32'd1);
      for (int i = 3; i <= 8; i++) begin
         applyStimulus(0, 0, 0, 0);
         @(negedge clk);
         checkOutput("t4_busy", 32'(md_busy), 32'(i <= 7));
      end

      // Scenario 5: reset asserted mid-cycle while a div is busy.
      do_reset();
      applyStimulus(1, 1, 1, 0);
      for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 0);
      @(negedge clk);
      checkOutput("t5_pre_busy", 32'(md_busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t5_busy", 32'(md_busy), 32'd0);
      checkOutput("t5_stall", 32'(stall), 32'd0);
      checkOutput("t5_perf", 32'(stall_cycles), 32'd0);
      applyStimulus(0, 0, 0, 0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t5_idle_fd", 32'(fd_enable), 32'd1);
      checkOutput("t5_idle_busy", 32'(md_busy), 32'd0);

      // Scenario 6: saturation of the narrow perf counter.
      do_reset();
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t6_perf4", 32'(stall_cycles4), 32'd15);
      checkOutput("t6_perf16", 32'(stall_cycles), 32'd20);

      // Randomized traffic, with occasional resets.
      do_reset();
      for (int i = 0; i < 500; i++) begin
         applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #2;
            reset = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b1;
         end
      end

      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
